// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM memory-stage SRAM controller.
//   - FSM state encoding (IDLE/LO/HI/DONE)
//   - data-memory base address default, SRAM data width
//   - latched operation encoding (RD/WR)
//   - word_index(): byte address -> word offset from the data-memory base
package arm_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
  localparam int          SRAM_DW       = 16;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Byte offset from base, divided by 4; address[1:0] drop out here.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side bus of the SRAM controller.
//   rd_en/wr_en   : MEM_R / MEM_W from the EXE/MEM register
//   address       : byte address (ALU result)
//   write_data    : store data
//   read_data     : registered load result
//   ready         : access complete / idle; the pipeline freezes on ~ready
// master = pipeline side, slave = controller side.
interface sram_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output rd_en, wr_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  rd_en, wr_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/sram_phase_timer.sv
// Loadable wait counter that times one half-word SRAM phase.
//   clk, rst    : clock, async active-low reset
//   start       : (re)load the counter to 0 and mark busy (phase entry)
//   busy        : a phase is being timed
//   phase_last  : busy and this is the final cycle of the phase
// A phase lasts WAIT_CYCLES cycles; start on the last cycle chains
// straight into the next phase.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic phase_last
);

  localparam int             CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (phase_last) busy <= 1'b0;
      else            cnt  <= cnt + 1'b1;
    end
  end

  assign phase_last = busy && (cnt == LAST);

endmodule

// File: rtl/sram_ctrl.sv
// Memory-stage controller: sequences a 16-bit single-port SRAM for the
// 32-bit pipeline data path. Each word access is a LO half-word phase then
// a HI half-word phase, each WAIT_CYCLES long, followed by one DONE cycle.
// Ports:
//   clk, rst        : pipeline clock, async active-low reset
//   bus (slave)     : rd_en, wr_en, address, write_data, read_data, ready
//   sram_addr       : half-word address {word, hi}
//   sram_dq_o/_i    : SRAM write / read data
//   sram_dq_oe      : 1 = drive dq
//   sram_we_n       : write strobe, active-low
//   sram_oe_n       : output enable, active-low
// Optional feature (macro SRAM_READ_BUF_EN): single-entry read buffer
// tagged with the word index; a read hit in IDLE completes with no SRAM
// access. Undefined: every read runs the full FSM.
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int          SRAM_AW     = 18
) (
  input  logic                clk,
  input  logic                rst,
  sram_ctrl_if.slave          bus,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_o,
  input  logic [SRAM_DW-1:0]  sram_dq_i,
  output logic                sram_dq_oe,
  output logic                sram_we_n,
  output logic                sram_oe_n
);

  localparam int WW = SRAM_AW - 1;  // word index width

  logic [1:0]         state, state_nx;
  op_e                op_q;
  logic [WW-1:0]      word_q;
  logic [31:0]        wdata_q;
  logic [SRAM_DW-1:0] lo_q;
  logic [31:0]        rdata_q;

  logic               req, hit, start_acc;
  logic               t_start, t_busy, t_last;
  logic [WW-1:0]      word_in;

  assign req     = bus.rd_en | bus.wr_en;
  // Truncation makes the map wrap modulo the SRAM size.
  assign word_in = WW'(word_index(bus.address, ADDR_BASE));

`ifdef SRAM_READ_BUF_EN
  logic          buf_vld;
  logic [WW-1:0] buf_tag;

  // wr_en wins a conflict, so only a pure read can hit.
  assign hit = (state == ST_IDLE) && bus.rd_en && !bus.wr_en &&
               buf_vld && (buf_tag == word_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld <= 1'b0;
      buf_tag <= '0;
    end else if ((state == ST_HI) && t_last && (op_q == OP_RD)) begin
      buf_vld <= 1'b1;
      buf_tag <= word_q;
    end else if (start_acc && bus.wr_en && (word_in == buf_tag)) begin
      buf_vld <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign start_acc = (state == ST_IDLE) && req && !hit;
  // Reload on LO entry and again on the LO->HI boundary.
  assign t_start   = start_acc || ((state == ST_LO) && t_last);

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (t_start),
    .busy       (t_busy),
    .phase_last (t_last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_acc) state_nx = ST_LO;
      ST_LO:   if (t_last)    state_nx = ST_HI;
      ST_HI:   if (t_last)    state_nx = ST_DONE;
      default:                state_nx = ST_IDLE;  // DONE always returns
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_RD;
      word_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        op_q    <= bus.wr_en ? OP_WR : OP_RD;
        word_q  <= word_in;
        wdata_q <= bus.write_data;
      end
      // Low half parks in lo_q so read_data only changes when a read completes.
      if (op_q == OP_RD && t_last) begin
        if (state == ST_LO) lo_q    <= sram_dq_i;
        if (state == ST_HI) rdata_q <= {sram_dq_i, lo_q};
      end
    end
  end

  // SRAM pins decode from state and latched operands only: no path from
  // the request inputs to the pins.
  logic phase_act, wr_act, rd_act;
  assign phase_act = (state == ST_LO) || (state == ST_HI);
  assign wr_act    = phase_act && (op_q == OP_WR);
  assign rd_act    = phase_act && (op_q == OP_RD);

  assign sram_addr  = {word_q, (state == ST_HI)};
  assign sram_dq_o  = wr_act ? ((state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0])
                             : '0;
  assign sram_dq_oe = wr_act;
  assign sram_we_n  = !wr_act;
  assign sram_oe_n  = !rd_act;

  assign bus.read_data = rdata_q;
  assign bus.ready     = ((state == ST_IDLE) && !req) || (state == ST_DONE) || hit;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;
  import arm_mem_pkg::*;

  localparam int          W    = 2;
  localparam int          AW   = 18;
  localparam int          LAT  = 2 * W + 1;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_ctrl_if bus ();

  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  sram_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(BASE), .SRAM_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  // external SRAM device
  logic [15:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = sram_oe_n ? 16'h0 : sram_mem[sram_addr];

  int checks = 0;
  int errors = 0;

  // word-level reference model
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rd = 32'h0;
  bit          bv = 1'b0;
  int unsigned btag = 0;

  function automatic int unsigned widx(input logic [31:0] a);
    return ((a - BASE) >> 2) % (1 << (AW - 1));
  endfunction

  // Applies one request to the model; returns the expected cycle of ready.
  function automatic int model_op(input bit rd, input bit wr,
                                  input logic [31:0] a, input logic [31:0] d);
    int unsigned w;
    w = widx(a);
    if (wr) begin
      ref_mem[w] = d;
      if (bv && btag == w) bv = 1'b0;
      return LAT;
    end
    if (rd) begin
`ifdef SRAM_READ_BUF_EN
      if (bv && btag == w) return 0;
      bv = 1'b1;
      btag = w;
`endif
      exp_rd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
      return LAT;
    end
    return 0;
  endfunction

  // per-cycle pin trace of the last access (cycle 0 = request cycle)
  logic [AW-1:0] t_addr [64];
  logic [15:0]   t_dq   [64];
  logic          t_we   [64];
  logic          t_oe   [64];
  logic          t_dqoe [64];
  logic [31:0]   t_rd;

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit immediate,
                        input int chg_cyc, input logic [31:0] chg_addr,
                        output int lat);
    if (!immediate) begin @(posedge clk); #1; end
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = d;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      t_addr[c] = sram_addr; t_dq[c] = sram_dq_o; t_we[c] = sram_we_n;
      t_oe[c] = sram_oe_n; t_dqoe[c] = sram_dq_oe; t_rd = bus.read_data;
      if (bus.ready) begin lat = c; break; end
      if (c == chg_cyc) bus.address = chg_addr;
    end
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h got no ready want ready within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    bus.rd_en = 0; bus.wr_en = 0; bus.address = 0; bus.write_data = 0;
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.read_data, sram_addr, sram_dq_o} !== '0) begin
      errors++;
      $display("FAIL reset_zero rd=%h addr=%h dq=%h want all 0", bus.read_data, sram_addr, sram_dq_o);
    end
    checks++;
    if ({sram_we_n, sram_oe_n, sram_dq_oe, bus.ready} !== 4'b1101) begin
      errors++;
      $display("FAIL reset_ctrl we_n,oe_n,dq_oe,ready=%b want 1101", {sram_we_n, sram_oe_n, sram_dq_oe, bus.ready});
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", bus.ready); end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    bus.wr_en = 1; bus.address = 32'h500; bus.write_data = $urandom;
    repeat (W + 2) @(negedge clk);  // now in the first HI cycle
    checks++;
    if ({sram_we_n, sram_addr[0]} !== 2'b01) begin
      errors++; $display("FAIL mid_hi_phase we_n,addr0=%b want 01", {sram_we_n, sram_addr[0]});
    end
    rst = 0; #1;
    checks++;
    if ({sram_we_n, sram_dq_oe, sram_oe_n} !== 3'b101) begin
      errors++; $display("FAIL mid_reset_pins we_n,dq_oe,oe_n=%b want 101", {sram_we_n, sram_dq_oe, sram_oe_n});
    end
    bus.wr_en = 0; #1;
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle ready=%b want 1", bus.ready); end
    @(negedge clk); rst = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({sram_we_n, bus.ready} !== 2'b11) begin
        errors++; $display("FAIL post_reset_quiet cyc=%0d we_n,ready=%b want 11", c, {sram_we_n, bus.ready});
      end
    end
    bv = 0; exp_rd = 32'h0;
    checks++;
    if (bus.read_data !== exp_rd) begin errors++; $display("FAIL post_reset_rdata got %h want %h", bus.read_data, exp_rd); end
  endtask

  task automatic test_single_write();
    int lat, el;
    el = model_op(0, 1, 32'h404, 32'hDEADBEEF);
    access(0, 1, 32'h404, 32'hDEADBEEF, 0, -1, 0, lat);
    checks++;
    if (lat !== 5 || lat !== el) begin errors++; $display("FAIL wr_latency got %0d want 5", lat); end
    checks++;
    if (t_we[0] !== 1'b1) begin errors++; $display("FAIL wr_req_cycle_idle we_n=%b want 1", t_we[0]); end
    for (int c = 1; c <= 2 * W; c++) begin
      logic [AW-1:0] ea;
      logic [15:0]   ed;
      ea = (c <= W) ? 18'h2 : 18'h3;
      ed = (c <= W) ? 16'hBEEF : 16'hDEAD;
      checks++;
      if (t_addr[c] !== ea || t_dq[c] !== ed || {t_we[c], t_dqoe[c], t_oe[c]} !== 3'b011) begin
        errors++;
        $display("FAIL wr_phase cyc=%0d addr=%h dq=%h we,dqoe,oe=%b want addr=%h dq=%h 011",
                 c, t_addr[c], t_dq[c], {t_we[c], t_dqoe[c], t_oe[c]}, ea, ed);
      end
    end
    checks++;
    if (t_we[LAT] !== 1'b1) begin errors++; $display("FAIL wr_done_we_n got %b want 1", t_we[LAT]); end
  endtask

  task automatic test_readback();
    int lat, el;
    el = model_op(1, 0, 32'h404, 0);
    access(1, 0, 32'h404, 0, 0, -1, 0, lat);
    checks++;
    if (lat !== el) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, el); end
    checks++;
    if (t_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", t_rd); end
    for (int c = 1; c <= 2 * W; c++) begin
      checks++;
      if ({t_oe[c], t_dqoe[c], t_we[c]} !== 3'b001) begin
        errors++; $display("FAIL rd_phase cyc=%0d oe,dqoe,we=%b want 001", c, {t_oe[c], t_dqoe[c], t_we[c]});
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.read_data !== 32'hDEADBEEF) begin
        errors++; $display("FAIL rd_hold cyc=%0d got %h want deadbeef", c, bus.read_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, el;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = ~d1;
    el = model_op(0, 1, 32'h408, d2);
    access(0, 1, 32'h408, d2, 0, -1, 0, lat);
    el = model_op(0, 1, 32'h404, d1);
    access(0, 1, 32'h404, d1, 0, -1, 0, lat);
    checks++;
    if (lat !== el) begin errors++; $display("FAIL b2b_wr_latency got %0d want %0d", lat, el); end
    el = model_op(1, 0, 32'h404, 0);
    access(1, 0, 32'h404, 0, 1, 2, 32'h408, lat);
    checks++;
    if (lat !== el) begin errors++; $display("FAIL b2b_rd_latency got %0d want %0d", lat, el); end
    checks++;
    if (t_oe[0] !== 1'b1 || t_oe[1] !== 1'b0) begin
      errors++; $display("FAIL b2b_start oe_n c0,c1=%b%b want 10", t_oe[0], t_oe[1]);
    end
    checks++;
    if (t_addr[1] !== 18'h2 || t_addr[W + 1] !== 18'h3) begin
      errors++; $display("FAIL b2b_latched_addr lo=%h hi=%h want 2 3", t_addr[1], t_addr[W + 1]);
    end
    checks++;
    if (t_rd !== exp_rd) begin errors++; $display("FAIL b2b_rd_data got %h want %h", t_rd, exp_rd); end
  endtask

  task automatic test_conflict_wrap();
    int lat, el;
    logic [31:0] prev, d, aw;
    prev = exp_rd; d = $urandom;
    el = model_op(1, 1, 32'h40C, d);
    access(1, 1, 32'h40C, d, 0, -1, 0, lat);
    checks++;
    if (lat !== el || t_we[1] !== 1'b0 || t_oe[1] !== 1'b1) begin
      errors++; $display("FAIL conflict_is_write lat=%0d we_n=%b oe_n=%b want %0d 0 1", lat, t_we[1], t_oe[1], el);
    end
    checks++;
    if (bus.read_data !== prev) begin errors++; $display("FAIL conflict_rdata got %h want %h", bus.read_data, prev); end
    el = model_op(1, 0, 32'h40C, 0);
    access(1, 0, 32'h40C, 0, 0, -1, 0, lat);
    checks++;
    if (t_rd !== exp_rd) begin errors++; $display("FAIL conflict_readback got %h want %h", t_rd, exp_rd); end
    aw = BASE + 32'd4 * (32'd1 << 17); d = $urandom;
    el = model_op(0, 1, aw, d);
    access(0, 1, aw, d, 0, -1, 0, lat);
    checks++;
    if (t_addr[1] !== 18'h0 || t_addr[W + 1] !== 18'h1) begin
      errors++; $display("FAIL wrap_addr lo=%h hi=%h want 0 1", t_addr[1], t_addr[W + 1]);
    end
    el = model_op(1, 0, BASE, 0);
    access(1, 0, BASE, 0, 0, -1, 0, lat);
    checks++;
    if (t_rd !== exp_rd) begin errors++; $display("FAIL wrap_readback got %h want %h", t_rd, exp_rd); end
  endtask

  task automatic test_repeat_read();
    int lat, el;
    logic [31:0] d;
    el = model_op(1, 0, 32'h404, 0);
    access(1, 0, 32'h404, 0, 0, -1, 0, lat);
    el = model_op(1, 0, 32'h404, 0);
    access(1, 0, 32'h404, 0, 0, -1, 0, lat);
    checks++;
    if (lat !== el) begin errors++; $display("FAIL repeat_rd_latency got %0d want %0d", lat, el); end
    checks++;
    if (t_rd !== exp_rd) begin errors++; $display("FAIL repeat_rd_data got %h want %h", t_rd, exp_rd); end
`ifdef SRAM_READ_BUF_EN
    @(negedge clk);
    checks++;
    if (t_oe[0] !== 1'b1 || sram_oe_n !== 1'b1) begin
      errors++; $display("FAIL buf_hit_no_oe oe_n=%b%b want 11", t_oe[0], sram_oe_n);
    end
`endif
    d = $urandom;
    el = model_op(0, 1, 32'h404, d);
    access(0, 1, 32'h404, d, 0, -1, 0, lat);
    el = model_op(1, 0, 32'h404, 0);
    access(1, 0, 32'h404, 0, 0, -1, 0, lat);
    checks++;
    if (lat !== LAT || lat !== el) begin errors++; $display("FAIL rd_after_wr_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (t_rd !== d) begin errors++; $display("FAIL rd_after_wr_data got %h want %h", t_rd, d); end
  endtask

  task automatic test_random();
    int lat, el;
    logic [31:0] a, d;
    bit rd, wr;
    for (int w = 0; w < 8; w++) begin
      d = $urandom;
      el = model_op(0, 1, BASE + 32'(w * 4), d);
      access(0, 1, BASE + 32'(w * 4), d, 0, -1, 0, lat);
    end
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      rd = (k != 2); wr = (k >= 2);
      a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      el = model_op(rd, wr, a, d);
      access(rd, wr, a, d, 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom, lat);
      checks++;
      if (lat !== el || t_rd !== exp_rd) begin
        errors++;
        $display("FAIL random i=%0d rd=%0d wr=%0d a=%h lat=%0d data=%h want lat=%0d data=%h",
                 i, rd, wr, a, lat, t_rd, el, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_single_write();
    test_readback();
    test_back_to_back();
    test_conflict_wrap();
    test_repeat_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-stage controller that sequences a single-port 16-bit external SRAM for the 32-bit ARM pipeline data path.
- Takes MEM_R/MEM_W requests from the EXE/MEM pipeline register. Splits each word into two half-word SRAM phases, each lasting a programmable number of wait cycles.
- Drops `ready` low for the whole access; the pipeline top uses `~ready` as freeze for all stage registers.

Parameters:
- WAIT_CYCLES, 2, cycles each half-word phase is held on the SRAM bus (≥1).
- ADDR_BASE, 1024, byte address of data-memory start; subtracted before mapping.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  MEM_R from EXE/MEM register
- wr_en  in  1  MEM_W from EXE/MEM register
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (val_rm)
- read_data  out  32  load result, registered
- ready  out  1  access complete / controller idle; freeze = ~ready
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_o  out  16  write data to SRAM
- sram_dq_i  in  16  read data from SRAM
- sram_dq_oe  out  1  tri-state enable for dq (1 = drive)
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
- Reset mid-access aborts immediately. No partial write is completed after reset release.
- Address map: word = (address − ADDR_BASE) >> 2, truncated to SRAM_AW−1 bits, so it wraps modulo SRAM size. Low half goes to {word,0}, high half to {word,1}. address[1:0] is ignored.
- FSM states:
  - IDLE: if rd_en|wr_en, latch op, word, write_data and go to LO; else stay.
  - LO: hold for WAIT_CYCLES cycles, then go to HI.
  - HI: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- The wait counter resets to 0 on each phase entry. The phase ends when counter == WAIT_CYCLES−1.
- ready (combinational from state) = (IDLE & ~rd_en & ~wr_en) | DONE.
- Latency: a request seen in IDLE at cycle 0 gives ready=0 for cycles 0..2·WAIT_CYCLES and ready=1 at cycle 2·WAIT_CYCLES+1. With the default, ready rises at cycle 5.
- Latched operands are used throughout the access; input changes after cycle 0 are ignored.
- Read: sram_oe_n=0 and sram_dq_oe=0 during LO/HI. read_data[15:0] is captured from sram_dq_i on the last LO cycle and read_data[31:16] on the last HI cycle. read_data holds until the next read completes; writes never change it.
- Write: sram_dq_oe=1 and sram_we_n=0 during LO/HI, with sram_oe_n=1. sram_dq_o = data[15:0] in LO and data[31:16] in HI.
- sram_we_n returns high for at least the DONE cycle.
- Simultaneous rd_en & wr_en: the write is performed and the read is ignored.
- DONE→IDLE is forced so a back-to-back request, presented after the pipeline advances, always starts a fresh access. There is no combinational path from the request to SRAM pins.

Optional Feature:
- Macro: SRAM_READ_BUF_EN.
- Defined: adds a single-entry read buffer (valid bit plus tag = latched word index). read_data is the buffer data.
  - In IDLE, a read whose word equals the tag while valid=1 is a hit: ready=1 in the same cycle, no SRAM activity, state stays IDLE.
  - A completed read sets tag and valid.
  - A write with word == tag clears valid at write start (LO entry).
  - Reset clears valid.
- Undefined: no buffer; every read takes the full FSM path.

Decomposition:
- Shared package arm_mem_pkg:
  - FSM state encoding: IDLE=0, LO=1, HI=2, DONE=3.
  - ADDR_BASE default, the 16-bit SRAM data width constant, and the op encoding (RD/WR).
- One natural sub-module, sram_phase_timer: loadable counter with input WAIT_CYCLES and outputs `phase_last`/`busy`. It is instantiated once.

Test Plan:
- Reset mid-access:
  - Stimulus: rst low during a write's HI phase.
  - Response: sram_we_n=1, sram_dq_oe=0 and state IDLE in the same cycle. ready=1 after release with no request.
- Single write:
  - Stimulus: address=0x404, data=0xDEADBEEF, WAIT_CYCLES=2.
  - Response: sram_addr=0x2 with dq=0xBEEF for 2 cycles, then sram_addr=0x3 with dq=0xDEAD for 2 cycles, we_n low in all 4. ready rises at cycle 5.
- Readback:
  - Stimulus: read of 0x404 against an SRAM model holding the values above.
  - Response: read_data=0xDEADBEEF when ready rises at cycle 5, held stable through 3 idle cycles.
- Back-to-back and operand stability:
  - Stimulus: read immediately after a write, with address changed to 0x408 at cycle 2 of the read.
  - Response: second access begins the cycle after DONE and uses the address latched at start.
- Conflict and wrap:
  - Stimulus 1: rd_en=wr_en=1 → a write is performed and read_data is unchanged.
  - Stimulus 2: address=ADDR_BASE+4·2^17 → sram_addr=0x0.
- SRAM_READ_BUF_EN:
  - Stimulus: repeat the read of 0x404.
  - Response: ready=1 in the request cycle with no oe_n activity.
  - Stimulus: write 0x404, then read 0x404.
  - Response: the read takes the full 5-cycle access.
